conv_pe_ctrl: RTL and testbench
===============================

Name: conv_pe_ctrl

Overview:
Sequencer for one conv_pe instance. Walks a conv job in the order pixel window → output filter (cout) → 8-channel input group (cin group), and issues activation/weight/bias read addresses. It drives the PE's valid_in/last_channel aligned to memory read latency. It gates each filter pass on output-FIFO credits and window availability, and signals job completion once every PE result has drained.

Parameters:
CG_W, 6, width of the cin-group count and index (1..2^CG_W-1 groups of 8 channels)
CO_W, 10, width of the output-filter count and index
PIX_W, 16, width of the pixel-window count
MEM_LAT, 1, cycles from rd_en to data at PE inputs (range 1..3)
PE_LAT, 4, cycles from pe_valid_in to pe_data_valid
FIFO_DEPTH, 16, downstream result FIFO depth (initial credits)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  high only in IDLE
cfg_cin_groups  in  CG_W  cin groups per filter (0 is treated as 1)
cfg_cout  in  CO_W  filters per pixel
cfg_npix  in  PIX_W  pixel windows in job
win_valid  in  1  line buffer holds a complete 3x3 window
win_consume  out  1  1-cycle pulse: window fully sampled, advance
rd_en  out  1  read strobe for activation/weight/bias memories
act_grp  out  CG_W  cin group index within window
wgt_addr  out  CO_W+CG_W  cout*groups + g
bias_addr  out  CO_W  current cout
pe_valid_in  out  1  to conv_pe valid_in
pe_last_channel  out  1  to conv_pe last_channel
pe_data_valid  in  1  from conv_pe data_valid
out_pop  in  1  downstream FIFO popped one result (returns one credit)
busy  out  1  job in progress (not IDLE)
done  out  1  1-cycle pulse at job end

Behaviour:
- Reset: state IDLE. All counters and the delay pipe cleared. Credits = FIFO_DEPTH, in-flight = 0. All outputs 0 except cfg_ready = 1.
- States:
  - IDLE: cfg_valid & cfg_ready latches the descriptor. If cfg_cout==0 or cfg_npix==0, go to DRAIN. Else go to WAIT_WIN.
  - WAIT_WIN: when win_valid, go to ISSUE with cout = 0, g = 0, wgt_addr = 0.
  - ISSUE: each cycle with rd_en = 1 issues one read; g increments and wgt_addr increments.
    - A pass starts at g = 0. It issues only if credits > 0; otherwise rd_en = 0 and the controller holds. It never stalls after g = 0 within a pass.
    - At g = groups-1, the pass ends. The in-flight counter increments and the last flag is tagged.
    - The next cout then follows back-to-back. After the last cout of the pixel, go to RELEASE.
  - RELEASE: wait until the delayed win_consume has been emitted. One cycle later, go to WAIT_WIN if pixels remain, else DRAIN. Win_valid is never sampled before the cycle after win_consume.
  - DRAIN: when in-flight == 0, pulse done for one cycle and go to IDLE.
- Alignment:
  - pe_valid_in and pe_last_channel are rd_en and the last-issue flag delayed exactly MEM_LAT cycles.
  - win_consume equals pe_last_channel of the final cout of each pixel, so the window holds through the PE sample.
  - A pe_data_valid result appears MEM_LAT+PE_LAT cycles after the last issue of its pass.
- Credits:
  - Decrement on a pass start (g = 0 issue); increment on out_pop.
  - Both in the same cycle: net unchanged.
  - out_pop with credits == FIFO_DEPTH is ignored (assertion fires in simulation).
- In-flight counter: increments at pass-end issue, decrements on pe_data_valid; simultaneous events leave it unchanged.
- Throughput: groups cycles per filter with zero bubbles when credits are available. Per-pixel overhead is MEM_LAT+2 cycles.
- Output registration: rd_en, addresses, pe_* and win_consume are registered; addresses are valid only when rd_en = 1.
- Reset mid-job: immediate return to IDLE; pending pe_valid_in is squashed, credits restore to FIFO_DEPTH, no done pulse.
- Descriptor fields are ignored outside the IDLE handshake.

Decomposition:
- Package conv_ctrl_pkg:
  - state enum (IDLE, WAIT_WIN, ISSUE, RELEASE, DRAIN)
  - PE_LANES = 8, PE_LAT = 4
  - descriptor struct {cin_groups, cout, npix}
- Sub-module conv_delay_line (parameterised width/depth shift register) for the MEM_LAT alignment of {valid, last, consume}.

Test Plan:
- groups=3, cout=2, npix=1, win_valid=1, MEM_LAT=1:
  - wgt_addr 0..5 issued on consecutive cycles.
  - pe_last_channel high 1 cycle after issues 2 and 5; win_consume with the second.
  - Two pe_data_valid, then done; busy low after.
- groups=1, cout=20, FIFO_DEPTH=16, no out_pop:
  - Exactly 16 passes issue, then rd_en stays 0.
  - Single out_pop → exactly one more pass.
  - Popping on every cycle thereafter → all 20 passes complete, done.
- npix=3, win_valid toggled low for 5 cycles after each win_consume:
  - No issue while win_valid is low; three win_consume pulses; bias_addr restarts at 0 each pixel.
- cfg_cout=0 (or cfg_npix=0):
  - No rd_en.
  - done 2 cycles after handshake.
  - cfg_ready returns high.
- cfg_cin_groups=0: behaves as 1; every issue has pe_last_channel = 1.
- rst asserted mid-ISSUE with an item in the delay pipe:
  - Next cycle all outputs 0 and cfg_ready = 1; no pe_valid_in or done afterwards.
  - New job runs correctly with credits = 16.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_ctrl_pkg
// Brief    : Shared constants, state encoding, job descriptor type and helper
//            for the conv_pe sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package conv_ctrl_pkg;

   // Channels consumed by the PE per read (one cin group)
   localparam int PE_LANES = 8;
   // conv_pe pipeline depth from valid_in to data_valid
   localparam int PE_LAT   = 4;

   // Descriptor field widths; the controller's CG_W/CO_W/PIX_W default to these
   localparam int DESC_CG_W  = 6;
   localparam int DESC_CO_W  = 10;
   localparam int DESC_PIX_W = 16;

   // Sequencer states
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_WIN = 3'd1;
   localparam logic [2:0] ST_ISSUE    = 3'd2;
   localparam logic [2:0] ST_RELEASE  = 3'd3;
   localparam logic [2:0] ST_DRAIN    = 3'd4;

   typedef struct packed {
      logic [DESC_CG_W-1:0]  cin_groups;
      logic [DESC_CO_W-1:0]  cout;
      logic [DESC_PIX_W-1:0] npix;
   } conv_desc_t;

   // A zero group count is run as a single group
   function automatic logic [DESC_CG_W-1:0] eff_groups(input logic [DESC_CG_W-1:0] groups);
      return (groups == '0) ? DESC_CG_W'(1) : groups;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : conv_delay_line
// Brief    : Resettable WIDTH x DEPTH shift register used to align read-side
//            strobes with memory read latency.
// Revision : 1.0 - initial release
// ============================================================================
module conv_delay_line
   import conv_ctrl_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   // Shift one stage per cycle; reset squashes everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_ctrl
// Brief    : Sequencer for one conv_pe. Walks pixel -> cout -> cin group,
//            issues memory reads, aligns PE strobes to read latency, gates
//            passes on FIFO credits and reports job completion.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pe_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int CG_W       = DESC_CG_W,
   parameter int CO_W       = DESC_CO_W,
   parameter int PIX_W      = DESC_PIX_W,
   parameter int MEM_LAT    = 1,
   parameter int FIFO_DEPTH = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CG_W-1:0]      cfg_cin_groups,
   input  logic [CO_W-1:0]      cfg_cout,
   input  logic [PIX_W-1:0]     cfg_npix,
   input  logic                 win_valid,
   output logic                 win_consume,
   output logic                 rd_en,
   output logic [CG_W-1:0]      act_grp,
   output logic [CO_W+CG_W-1:0] wgt_addr,
   output logic [CO_W-1:0]      bias_addr,
   output logic                 pe_valid_in,
   output logic                 pe_last_channel,
   input  logic                 pe_data_valid,
   input  logic                 out_pop,
   output logic                 busy,
   output logic                 done
);

   localparam int                CRED_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

   logic [2:0]           state;
   conv_desc_t           desc;
   logic [CG_W-1:0]      grp_idx, grp_last;
   logic [CO_W-1:0]      cout_idx, cout_last;
   logic [PIX_W-1:0]     pix_idx, pix_last;
   logic [CO_W+CG_W-1:0] wgt_idx;
   logic [CRED_W-1:0]    credits, in_flight;
   logic                 issue, pass_start, pass_end, pix_end, pop_ok;
   logic                 rd_last, rd_consume;
   logic [2:0]           pipe_out;

   assign grp_last  = CG_W'(eff_groups(desc.cin_groups)) - CG_W'(1);
   assign cout_last = CO_W'(desc.cout) - CO_W'(1);
   assign pix_last  = PIX_W'(desc.npix) - PIX_W'(1);

   // Only a pass start needs a credit; once started a pass runs to its end
   assign issue      = (state == ST_ISSUE) && ((grp_idx != '0) || (credits != '0));
   assign pass_start = issue && (grp_idx == '0);
   assign pass_end   = issue && (grp_idx == grp_last);
   assign pix_end    = pass_end && (cout_idx == cout_last);
   assign pop_ok     = out_pop && (credits != CRED_FULL);

   assign cfg_ready = (state == ST_IDLE);
   assign busy      = ~cfg_ready;

   // Job walk: descriptor capture, window wait, group/cout/pixel stepping
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         desc     <= '0;
         grp_idx  <= '0;
         cout_idx <= '0;
         wgt_idx  <= '0;
         pix_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  desc.cin_groups <= DESC_CG_W'(cfg_cin_groups);
                  desc.cout       <= DESC_CO_W'(cfg_cout);
                  desc.npix       <= DESC_PIX_W'(cfg_npix);
                  pix_idx         <= '0;
                  state <= ((cfg_cout == '0) || (cfg_npix == '0)) ? ST_DRAIN : ST_WAIT_WIN;
               end
            end
            ST_WAIT_WIN: begin
               if (win_valid) begin
                  grp_idx  <= '0;
                  cout_idx <= '0;
                  wgt_idx  <= '0;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue) begin
                  wgt_idx <= wgt_idx + (CO_W+CG_W)'(1);
                  if (pass_end) begin
                     grp_idx <= '0;
                     if (pix_end) state    <= ST_RELEASE;
                     else         cout_idx <= cout_idx + CO_W'(1);
                  end else begin
                     grp_idx <= grp_idx + CG_W'(1);
                  end
               end
            end
            ST_RELEASE: begin
               // Window is released only after the PE has sampled it
               if (win_consume) begin
                  if (pix_idx == pix_last) begin
                     state <= ST_DRAIN;
                  end else begin
                     pix_idx <= pix_idx + PIX_W'(1);
                     state   <= ST_WAIT_WIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (in_flight == '0) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Credit and in-flight bookkeeping; coincident up/down events cancel
   always_ff @(posedge clk) begin
      if (rst) begin
         credits   <= CRED_FULL;
         in_flight <= '0;
      end else begin
         case ({pass_start, pop_ok})
            2'b10:   credits <= credits - CRED_W'(1);
            2'b01:   credits <= credits + CRED_W'(1);
            default: credits <= credits;
         endcase
         case ({pass_end, pe_data_valid})
            2'b10:   in_flight <= in_flight + CRED_W'(1);
            2'b01:   if (in_flight != '0) in_flight <= in_flight - CRED_W'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   // Registered read strobe, addresses and completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_en      <= 1'b0;
         rd_last    <= 1'b0;
         rd_consume <= 1'b0;
         act_grp    <= '0;
         wgt_addr   <= '0;
         bias_addr  <= '0;
         done       <= 1'b0;
      end else begin
         rd_en      <= issue;
         rd_last    <= pass_end;
         rd_consume <= pix_end;
         done       <= (state == ST_DRAIN) && (in_flight == '0);
         if (issue) begin
            act_grp   <= grp_idx;
            wgt_addr  <= wgt_idx;
            bias_addr <= cout_idx;
         end
      end
   end

   conv_delay_line #(
      .WIDTH (3),
      .DEPTH (MEM_LAT)
   ) u_align (
      .clk  (clk),
      .rst  (rst),
      .din  ({rd_en, rd_last, rd_consume}),
      .dout (pipe_out)
   );

   assign {pe_valid_in, pe_last_channel, win_consume} = pipe_out;

   // A pop with every credit already home means the downstream FIFO misbehaved
   a_pop_overflow: assert property (@(posedge clk) disable iff (rst)
      !(out_pop && (credits == CRED_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pe_ctrl
// Brief    : Scoreboard bench for conv_pe_ctrl with a PE latency model and a
//            downstream FIFO credit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pe_ctrl;
   import conv_ctrl_pkg::*;

   localparam int CG_W    = 6;
   localparam int CO_W    = 10;
   localparam int PIX_W   = 16;
   localparam int MEM_LAT = 1;
   localparam int FDEPTH  = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cfg_valid, cfg_ready;
   logic [CG_W-1:0]      cfg_cin_groups;
   logic [CO_W-1:0]      cfg_cout;
   logic [PIX_W-1:0]     cfg_npix;
   logic                 win_valid, win_consume, rd_en;
   logic [CG_W-1:0]      act_grp;
   logic [CO_W+CG_W-1:0] wgt_addr;
   logic [CO_W-1:0]      bias_addr;
   logic                 pe_valid_in, pe_last_channel, pe_data_valid;
   logic                 out_pop, busy, done;

   conv_pe_ctrl #(
      .CG_W(CG_W), .CO_W(CO_W), .PIX_W(PIX_W), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FDEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_cin_groups(cfg_cin_groups), .cfg_cout(cfg_cout), .cfg_npix(cfg_npix),
      .win_valid(win_valid), .win_consume(win_consume),
      .rd_en(rd_en), .act_grp(act_grp), .wgt_addr(wgt_addr), .bias_addr(bias_addr),
      .pe_valid_in(pe_valid_in), .pe_last_channel(pe_last_channel),
      .pe_data_valid(pe_data_valid), .out_pop(out_pop),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct { int grp; int wgt; int bias; bit last; bit cons; } iss_t;
   typedef struct { int due; bit last; bit cons; } pe_t;

   iss_t exp_q[$];
   pe_t  pe_q[$];

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   int n_issue = 0, n_res = 0, n_cons = 0, n_pev = 0, done_cnt = 0, done_cyc = 0;
   int first_iss = -1, last_iss = -1, hs_cyc = 0;
   int fifo_cnt = 0, pop_req = 0, win_low = 0;
   bit pop_mode = 0, win_mode = 0;
   logic [PE_LAT-1:0] pe_sr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // PE model: result appears PE_LAT cycles after a last-channel sample
   always @(posedge clk) begin
      if (rst) pe_sr <= '0;
      else     pe_sr <= {pe_sr[PE_LAT-2:0], pe_valid_in & pe_last_channel};
   end
   assign pe_data_valid = pe_sr[PE_LAT-1];

   // Downstream FIFO occupancy
   always @(posedge clk) begin
      if (rst) fifo_cnt <= 0;
      else     fifo_cnt <= fifo_cnt + int'(pe_data_valid) - int'(out_pop);
   end

   // Scoreboard flush on reset: nothing issued before reset may surface
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         pe_q.delete();
      end
   end

   // Pop driver
   always @(negedge clk) begin
      if (pop_mode && fifo_cnt > 0) out_pop = 1'b1;
      else if (pop_req > 0 && fifo_cnt > 0) begin
         out_pop = 1'b1;
         pop_req--;
      end else out_pop = 1'b0;
   end

   // Window driver: optionally drops win_valid for 5 cycles after each consume
   always @(negedge clk) begin
      if (win_mode) begin
         if (!win_valid) check_eq("no_issue_win_low", rd_en, 0);
         if (win_consume) begin
            win_valid = 1'b0;
            win_low   = 5;
         end else if (win_low > 0) begin
            win_low--;
            if (win_low == 0) win_valid = 1'b1;
         end
      end else begin
         win_valid = 1'b1;
      end
   end

   // Output monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) begin
            n_issue++;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
            check_eq("issue_expected", rd_en, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               iss_t e;
               e = exp_q.pop_front();
               check_eq("act_grp", act_grp, e.grp);
               check_eq("wgt_addr", wgt_addr, e.wgt);
               check_eq("bias_addr", bias_addr, e.bias);
               pe_q.push_back('{due: cyc + MEM_LAT, last: e.last, cons: e.cons});
            end
         end
         if (pe_valid_in) n_pev++;
         if (pe_valid_in || win_consume || (pe_q.size() != 0 && pe_q[0].due == cyc)) begin
            bit due_now;
            bit exp_cons;
            due_now  = (pe_q.size() != 0) && (pe_q[0].due == cyc);
            exp_cons = 1'b0;
            check_eq("pe_valid", pe_valid_in, due_now);
            if (due_now) begin
               pe_t p;
               p = pe_q.pop_front();
               check_eq("pe_last", pe_last_channel, p.last);
               exp_cons = p.cons;
            end
            check_eq("win_consume", win_consume, exp_cons);
         end
         if (win_consume)   n_cons++;
         if (pe_data_valid) n_res++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic push_job(input int grp, input int co, input int np);
      int g_eff;
      g_eff = (grp == 0) ? 1 : grp;
      for (int p = 0; p < np; p++)
         for (int c = 0; c < co; c++)
            for (int g = 0; g < g_eff; g++)
               exp_q.push_back('{grp: g, wgt: c * g_eff + g, bias: c,
                                 last: (g == g_eff - 1),
                                 cons: (g == g_eff - 1) && (c == co - 1)});
   endtask

   task automatic start_job(input int grp, input int co, input int np);
      @(negedge clk);
      check_eq("cfg_ready_idle", cfg_ready, 1);
      cfg_valid      = 1'b1;
      cfg_cin_groups = CG_W'(grp);
      cfg_cout       = CO_W'(co);
      cfg_npix       = PIX_W'(np);
      hs_cyc         = cyc;
      push_job(grp, co, np);
      @(negedge clk);
      cfg_valid      = 1'b0;
      cfg_cin_groups = CG_W'($urandom);
      cfg_cout       = CO_W'($urandom);
      cfg_npix       = PIX_W'($urandom);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq({tag, "_done"}, done_cnt - d0, 1);
   endtask

   task automatic finish_job(input string tag);
      wait_done(tag, 3000);
      @(negedge clk);
      check_eq({tag, "_busy_low"}, busy, 0);
      check_eq({tag, "_issue_q_empty"}, exp_q.size(), 0);
      check_eq({tag, "_pe_q_empty"}, pe_q.size(), 0);
   endtask

   task automatic drain_fifo();
      int k;
      k = 0;
      pop_mode = 1;
      while (fifo_cnt != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      pop_mode = 0;
      check_eq("fifo_drained", fifo_cnt, 0);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int base, res0, cons0, d0, pv0;
      rst = 1'b1; cfg_valid = 1'b0; cfg_cin_groups = '0; cfg_cout = '0; cfg_npix = '0;
      win_valid = 1'b1; out_pop = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_ctrl", {rd_en, pe_valid_in, pe_last_channel, win_consume, done, busy}, 0);
      check_eq("rst_addr", {act_grp, wgt_addr, bias_addr}, 0);
      check_eq("rst_cfg_ready", cfg_ready, 1);
      rst = 1'b0;
      $display("lanes per group: %0d", PE_LANES);

      // 3 groups x 2 filters x 1 pixel: six consecutive reads
      base = n_issue; res0 = n_res; cons0 = n_cons; first_iss = -1;
      start_job(3, 2, 1);
      finish_job("t1");
      check_eq("t1_issues", n_issue - base, 6);
      check_eq("t1_issue_span", last_iss - first_iss, 5);
      check_eq("t1_results", n_res - res0, 2);
      check_eq("t1_consume", n_cons - cons0, 1);
      drain_fifo();

      // Credit gating: 20 single-group passes against 16 credits
      base = n_issue;
      start_job(1, 20, 1);
      repeat (40) @(negedge clk);
      check_eq("t2_stalled_passes", n_issue - base, 16);
      check_eq("t2_rd_idle", rd_en, 0);
      pop_req = 1;
      repeat (30) @(negedge clk);
      check_eq("t2_one_more_pass", n_issue - base, 17);
      pop_mode = 1;
      finish_job("t2");
      check_eq("t2_all_passes", n_issue - base, 20);
      drain_fifo();

      // Three pixels with the window withdrawn after each consume
      base = n_issue; cons0 = n_cons;
      win_mode = 1;
      start_job(2, 2, 3);
      finish_job("t3");
      win_mode = 0;
      check_eq("t3_issues", n_issue - base, 12);
      check_eq("t3_consume", n_cons - cons0, 3);
      drain_fifo();

      // Empty jobs complete without any read
      base = n_issue;
      start_job(2, 0, 2);
      wait_done("t4a", 20);
      check_eq("t4a_done_latency", done_cyc - hs_cyc, 2);
      check_eq("t4a_ready", cfg_ready, 1);
      start_job(2, 3, 0);
      wait_done("t4b", 20);
      check_eq("t4b_done_latency", done_cyc - hs_cyc, 2);
      check_eq("t4b_ready", cfg_ready, 1);
      check_eq("t4_no_issue", n_issue - base, 0);

      // Zero cin groups runs as one group; every read is a last channel
      base = n_issue;
      start_job(0, 3, 1);
      finish_job("t5");
      check_eq("t5_issues", n_issue - base, 3);
      drain_fifo();

      // Reset in the middle of ISSUE with a read in the alignment pipe
      base = n_issue;
      start_job(4, 4, 1);
      begin
         int k;
         k = 0;
         while ((n_issue - base) < 3 && k < 50) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq("t6_reached_issue", rd_en, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_ctrl", {rd_en, pe_valid_in, pe_last_channel, win_consume, done, busy}, 0);
      check_eq("t6_rst_ready", cfg_ready, 1);
      rst = 1'b0;
      d0 = done_cnt; pv0 = n_pev;
      repeat (20) @(negedge clk);
      check_eq("t6_no_pe_valid", n_pev - pv0, 0);
      check_eq("t6_no_done", done_cnt - d0, 0);
      base = n_issue;
      start_job(1, 20, 1);
      repeat (40) @(negedge clk);
      check_eq("t6_credits_restored", n_issue - base, 16);
      pop_mode = 1;
      finish_job("t6");
      check_eq("t6_all_passes", n_issue - base, 20);
      drain_fifo();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
